// File: rtl/tdm_mult_fifo.sv
// tdm_mult_fifo: N-channel time-division-multiplexed multiply engine.
// A work-conserving round-robin arbiter grants one requesting channel per
// cycle. The granted sample is multiplied by a wrapping coefficient counter
// in a 3-stage pipeline. Tagged products land in a first-word-fall-through
// output FIFO. Issue is gated by a credit check, so the FIFO cannot overflow.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   din         channel samples, channel c at [c*WIDTH +: WIDTH]
//   din_valid   per-channel request
//   din_ready   one-hot grant (combinational from state and din_valid)
//   dout        unsigned product at the FIFO head
//   dout_ch     channel tag of the head entry
//   dout_valid  FIFO non-empty
//   dout_ready  consumer accept
//   fifo_count  current FIFO occupancy
module tdm_mult_fifo #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned FINAL_COUNT = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH*WIDTH-1:0]       din,
    input  logic [NUM_CH-1:0]             din_valid,
    output logic [NUM_CH-1:0]             din_ready,
    output logic [2*WIDTH-1:0]            dout,
    output logic [$clog2(NUM_CH)-1:0]     dout_ch,
    output logic                          dout_valid,
    input  logic                          dout_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PW    = 2 * WIDTH;
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    // Round-robin search offset, wrapped into the channel range.
    function automatic logic [CH_W-1:0] wrap_idx(input logic [CH_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_CH) s = s - NUM_CH;
        return CH_W'(s);
    endfunction

    logic [CH_W-1:0]  ptr;
    logic [WIDTH-1:0] coef;

    logic [WIDTH-1:0] s1_a, s1_b;
    logic [CH_W-1:0]  s1_ch, s2_ch, s3_ch;
    logic             s1_v, s2_v, s3_v;
    logic [PW-1:0]    s2_p, s3_p;

    logic [PW-1:0]    mem_p  [FIFO_DEPTH];
    logic [CH_W-1:0]  mem_ch [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic             gnt_found;
    logic [CH_W-1:0]  gnt_idx;
    logic [WIDTH-1:0] sel_a;
    logic             issue_ok;
    logic             accept;
    logic             wr_en, rd_en;

    // First requester after the last granted channel.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            if (!gnt_found && din_valid[wrap_idx(ptr, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(ptr, i);
            end
        end
    end

    // Sample of the granted channel.
    always_comb begin
        sel_a = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (gnt_idx == CH_W'(c)) sel_a = din[c*WIDTH +: WIDTH];
        end
    end

    // Conservative credit: a same-cycle read is not counted as freeing a slot.
    assign issue_ok = (32'(count) + 32'(s1_v) + 32'(s2_v) + 32'(s3_v)) < FIFO_DEPTH;

    // Gated by rst so the grant reads zero while reset is held.
    assign accept = rst && issue_ok && gnt_found;

    always_comb begin
        din_ready = '0;
        if (accept) din_ready[gnt_idx] = 1'b1;
    end

    // Arbiter pointer, coefficient counter and multiply pipeline.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr   <= CH_W'(NUM_CH - 1);
            coef  <= '0;
            s1_a  <= '0;
            s1_b  <= '0;
            s1_ch <= '0;
            s1_v  <= 1'b0;
            s2_p  <= '0;
            s2_ch <= '0;
            s2_v  <= 1'b0;
            s3_p  <= '0;
            s3_ch <= '0;
            s3_v  <= 1'b0;
        end else begin
            s1_v <= accept;
            if (accept) begin
                ptr   <= gnt_idx;
                coef  <= (coef == WIDTH'(FINAL_COUNT)) ? '0 : coef + WIDTH'(1);
                s1_a  <= sel_a;
                s1_b  <= coef;
                s1_ch <= gnt_idx;
            end
            s2_p  <= PW'(s1_a) * PW'(s1_b);
            s2_ch <= s1_ch;
            s2_v  <= s1_v;
            s3_p  <= s2_p;
            s3_ch <= s2_ch;
            s3_v  <= s2_v;
        end
    end

    assign wr_en = s3_v;
    assign rd_en = dout_valid && dout_ready;

    // Output FIFO storage and pointers; storage is cleared so dout reads 0 after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_p[i]  <= '0;
                mem_ch[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem_p[wr_ptr]  <= s3_p;
                mem_ch[wr_ptr] <= s3_ch;
                wr_ptr         <= wr_ptr + AW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // First-word fall-through head.
    assign dout       = mem_p[rd_ptr];
    assign dout_ch    = mem_ch[rd_ptr];
    assign dout_valid = (count != '0);
    assign fifo_count = count;

endmodule
